// File: rtl/irq_arbiter.sv
`default_nettype none
//==============================================================================
// irq_arbiter - arbitrates active-low slot interrupts onto one CPU line and
// sequences the IACK handshake. Optional macro: IRQ_ACK_TIMEOUT_EN. Rev 1.0
//==============================================================================
module irq_arbiter #(
  parameter int         NUM_SLOTS    = 5,
  parameter int         SLOT_W       = 3,
  parameter logic [7:0] IRQ_CFG_BASE = 8'hC0,
  parameter int         ACK_TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SLOTS-1:0] i_slot_irq_n,
  input  logic                 i_iack_n,
  input  logic                 i_cfg_we,
  input  logic [7:0]           i_cfg_addr,
  input  logic [7:0]           i_cfg_wdata,
  output logic                 o_cpu_int_n,
  output logic                 o_irq_int_active,
  output logic [SLOT_W-1:0]    o_irq_int_slot,
  output logic                 o_irq_vec_cycle,
  output logic [NUM_SLOTS-1:0] o_irq_pending,
  output logic                 o_spurious_ack,
  output logic                 o_ack_timeout
);

  localparam logic [7:0] c_MODE_ADDR = IRQ_CFG_BASE + 8'd1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_VECTOR  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_SLOTS-1:0]  r_sync1;
  logic [NUM_SLOTS-1:0]  r_sync2;
  logic [NUM_SLOTS-1:0]  r_enable;
  logic                  r_mode;
  logic [NUM_SLOTS-1:0]  w_pending;
  logic [NUM_SLOTS-1:0]  w_ge_mask;
  logic [NUM_SLOTS-1:0]  w_upper;
  logic                  w_any;
  logic [SLOT_W-1:0]     w_winner;
  logic [SLOT_W-1:0]     r_slot;
  logic [SLOT_W-1:0]     w_slot_nxt;
  logic [SLOT_W-1:0]     r_rr_ptr;
  logic [SLOT_W-1:0]     w_rr_nxt;
  logic                  r_cpu_int_n;
  logic                  r_active;
  logic                  r_iack_d;
  logic                  r_spurious;
  logic                  w_to_hit;
  logic                  w_unused_cfg;

  assign w_unused_cfg = ^i_cfg_wdata;

  function automatic logic [SLOT_W-1:0] f_lowest(input logic [NUM_SLOTS-1:0] v);
    f_lowest = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = SLOT_W'(i);
    end
  endfunction

  // Request synchronizer; slot lines are asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_slot_irq_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pending = ~r_sync2 & r_enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable <= '0;
      r_mode   <= 1'b0;
    end else if (i_cfg_we) begin
      if (i_cfg_addr == IRQ_CFG_BASE) r_enable <= i_cfg_wdata[NUM_SLOTS-1:0];
      if (i_cfg_addr == c_MODE_ADDR)  r_mode   <= i_cfg_wdata[0];
    end
  end

  // Round-robin: lowest pending at or above rr_ptr, else wrap to lowest overall.
  always_comb begin
    w_ge_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_ge_mask[i] = (SLOT_W'(i) >= r_rr_ptr);
    end
    w_upper = w_pending & w_ge_mask;
    w_any   = |w_pending;
    if (r_mode || (w_upper == '0)) w_winner = f_lowest(w_pending);
    else                           w_winner = f_lowest(w_upper);
  end

`ifdef IRQ_ACK_TIMEOUT_EN
  localparam int c_TO_W = (ACK_TIMEOUT >= 256) ? $clog2(ACK_TIMEOUT + 1) : 8;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ACK_TIMEOUT - 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_ack_to;

  // Counter sits at zero outside PENDING, so it is clear on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_ack_to <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == S_PENDING) ? r_to_cnt + c_TO_W'(1) : '0;
      r_ack_to <= (r_state == S_PENDING) && (w_state_nxt == S_RELEASE);
    end
  end

  assign w_to_hit      = (r_to_cnt == c_TO_LAST);
  assign o_ack_timeout = r_ack_to;
`else
  assign w_to_hit      = 1'b0;
  assign o_ack_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_PENDING;
          w_slot_nxt  = w_winner;
        end
      end
      S_PENDING: begin
        if (!i_iack_n)              w_state_nxt = S_VECTOR;
        else if (!w_pending[r_slot]) w_state_nxt = S_IDLE;
        else if (w_to_hit)          w_state_nxt = S_RELEASE;
      end
      S_VECTOR: begin
        if (i_iack_n) w_state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
        w_rr_nxt    = (r_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_slot + SLOT_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_slot      <= '0;
      r_rr_ptr    <= '0;
      r_cpu_int_n <= 1'b1;
      r_active    <= 1'b0;
      r_iack_d    <= 1'b1;
      r_spurious  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot      <= w_slot_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_cpu_int_n <= (w_state_nxt != S_PENDING);
      r_active    <= (w_state_nxt == S_PENDING) || (w_state_nxt == S_VECTOR);
      r_iack_d    <= i_iack_n;
      r_spurious  <= (r_state == S_IDLE) && !i_iack_n && r_iack_d;
    end
  end

  assign o_cpu_int_n      = r_cpu_int_n;
  assign o_irq_int_active = r_active;
  assign o_irq_int_slot   = r_slot;
  assign o_irq_vec_cycle  = r_active & ~i_iack_n;
  assign o_irq_pending    = w_pending;
  assign o_spurious_ack   = r_spurious;

endmodule
`default_nettype wire
